// File: rtl/vec_sub_unpack.sv
// vec_sub_unpack: reads one packed sum row and one packed subtrahend row a
// word at a time, forms the per-byte field difference (res - vec) and
// streams the recovered bytes into the byte-wide S memory starting at
// S_START_ADDR. Pad bytes in the final word are never written.
//
// Optional build macro: VEC_SUB_UNPACK_NZ_FLAG_EN adds o_nonzero, a sticky
// flag set whenever a nonzero byte is written during the current run.
module vec_sub_unpack #(
    parameter string FIELD              = "GF256",
    parameter string PARAMETER_SET      = "L1",
    parameter int    MAT_ROW_SIZE_BYTES = (PARAMETER_SET == "L5") ? 202 :
                                          (PARAMETER_SET == "L3") ? 159 : 104,
    parameter int    M                  = (PARAMETER_SET == "L5") ? 480 :
                                          (PARAMETER_SET == "L3") ? 352 : 230,
    parameter int    S_START_ADDR       = (PARAMETER_SET == "L5") ? 150 :
                                          (PARAMETER_SET == "L3") ? 120 : 126,
    parameter int    N_GF               = 8,
    parameter int    PROC_SIZE          = N_GF * 8,
    localparam int   W                  = (MAT_ROW_SIZE_BYTES + N_GF - 1) / N_GF,
    localparam int   VEC_AW             = (W > 1) ? $clog2(W) : 1,
    localparam int   S_AW               = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_vec_rd,
    output logic [VEC_AW-1:0]    o_vec_addr,
    input  logic [PROC_SIZE-1:0] i_res,
    input  logic [PROC_SIZE-1:0] i_vec,
    output logic                 o_s_wr_en,
    output logic [S_AW-1:0]      o_s_addr,
    output logic [7:0]           o_s,
    output logic                 o_done
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
    ,
    output logic                 o_nonzero
`endif
);

    // Bytes carried by the final word; the rest of that word is padding.
    localparam int LAST_BYTES = MAT_ROW_SIZE_BYTES - N_GF * (W - 1);
    localparam int CNT_W      = $clog2(N_GF + 1);
    localparam bit IS_P251    = (FIELD == "P251");

    localparam logic [S_AW-1:0]   START_ADDR = S_AW'(S_START_ADDR);
    localparam logic [VEC_AW-1:0] LAST_WORD  = VEC_AW'(W - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(N_GF);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(LAST_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [PROC_SIZE-1:0]   shift_reg;
    logic [PROC_SIZE-1:0]   diff;
    logic [VEC_AW-1:0]      word_cnt;
    logic [CNT_W-1:0]       byte_cnt;
    logic [CNT_W-1:0]       word_bytes;

    // Subtraction modulo 251: borrow is repaired by adding the modulus back.
    // Done in 9 bits so the wrapped intermediate lands on the right residue.
    function automatic logic [7:0] p251_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} - {1'b0, b} + 9'd251;
        end
        return t[7:0];
    endfunction

    // Per-byte field difference of the word currently on the read bus.
    always_comb begin
        diff = '0;
        for (int j = 0; j < N_GF; j++) begin
            if (IS_P251) begin
                diff[PROC_SIZE-8*j-1 -: 8] = p251_sub(i_res[PROC_SIZE-8*j-1 -: 8],
                                                      i_vec[PROC_SIZE-8*j-1 -: 8]);
            end else begin
                diff[PROC_SIZE-8*j-1 -: 8] = i_res[PROC_SIZE-8*j-1 -: 8] ^
                                             i_vec[PROC_SIZE-8*j-1 -: 8];
            end
        end
    end

    // Number of real bytes in the word being emitted.
    always_comb begin
        word_bytes = (word_cnt == LAST_WORD) ? LAST_CNT : FULL_CNT;
    end

    // Main sequencer: fetch a word, load its differences, emit bytes MSB first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            o_vec_rd   <= 1'b0;
            o_vec_addr <= '0;
            o_s_wr_en  <= 1'b0;
            o_s_addr   <= START_ADDR;
            o_s        <= '0;
            o_done     <= 1'b0;
            shift_reg  <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_vec_addr <= '0;
                    o_s_addr   <= START_ADDR;
                    word_cnt   <= '0;
                    if (i_start) begin
                        state    <= S_FETCH;
                        o_vec_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    o_vec_rd <= 1'b0;
                    state    <= S_LOAD;
                end
                S_LOAD: begin
                    o_s       <= diff[PROC_SIZE-1 -: 8];
                    shift_reg <= diff << 8;
                    o_s_wr_en <= 1'b1;
                    byte_cnt  <= CNT_W'(1);
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (byte_cnt == word_bytes) begin
                        o_s_wr_en <= 1'b0;
                        if (word_cnt == LAST_WORD) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            word_cnt   <= word_cnt + 1'b1;
                            o_vec_addr <= word_cnt + 1'b1;
                            o_vec_rd   <= 1'b1;
                            o_s_addr   <= o_s_addr + 1'b1;
                            state      <= S_FETCH;
                        end
                    end else begin
                        o_s       <= shift_reg[PROC_SIZE-1 -: 8];
                        shift_reg <= shift_reg << 8;
                        byte_cnt  <= byte_cnt + 1'b1;
                        o_s_addr  <= o_s_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    o_done     <= 1'b0;
                    o_s_addr   <= START_ADDR;
                    o_vec_addr <= '0;
                    word_cnt   <= '0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
    // Sticky record of any nonzero byte written since the last accepted start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_nonzero <= 1'b0;
        end else if (state == S_IDLE && i_start) begin
            o_nonzero <= 1'b0;
        end else if (o_s_wr_en && (o_s != 8'd0)) begin
            o_nonzero <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_sub_unpack.sv
// Testbench for vec_sub_unpack: one GF256/L1 instance and one small P251
// instance (10 bytes, 8 bytes per word, S start 3), each with its own
// registered word memories. Directed runs with hand-computed expectations.
module tb_vec_sub_unpack;

    localparam int P_START = 3;
    localparam int P_BYTES = 10;

    logic clk = 1'b0;
    logic rst;
    logic start_l1;
    logic start_p;
    bit   sel;

    always #5 clk = ~clk;

    logic        l1_rd;
    logic [3:0]  l1_vaddr;
    logic [63:0] l1_res, l1_vec;
    logic        l1_wr;
    logic [7:0]  l1_saddr;
    logic [7:0]  l1_s;
    logic        l1_done;

    logic        p_rd;
    logic [0:0]  p_vaddr;
    logic [63:0] p_res, p_vec;
    logic        p_wr;
    logic [3:0]  p_saddr;
    logic [7:0]  p_s;
    logic        p_done;

`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
    logic l1_nz, p_nz;
`endif

    logic [63:0] l1_res_mem [13];
    logic [63:0] l1_vec_mem [13];
    logic [63:0] p_res_mem  [2];
    logic [63:0] p_vec_mem  [2];

    vec_sub_unpack #(
        .FIELD("GF256"),
        .PARAMETER_SET("L1")
    ) dut_l1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_l1),
        .o_vec_rd(l1_rd), .o_vec_addr(l1_vaddr),
        .i_res(l1_res), .i_vec(l1_vec),
        .o_s_wr_en(l1_wr), .o_s_addr(l1_saddr), .o_s(l1_s),
        .o_done(l1_done)
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
        , .o_nonzero(l1_nz)
`endif
    );

    vec_sub_unpack #(
        .FIELD("P251"),
        .PARAMETER_SET("L1"),
        .MAT_ROW_SIZE_BYTES(P_BYTES),
        .M(16),
        .S_START_ADDR(P_START),
        .N_GF(8)
    ) dut_p (
        .i_clk(clk), .i_rst(rst), .i_start(start_p),
        .o_vec_rd(p_rd), .o_vec_addr(p_vaddr),
        .i_res(p_res), .i_vec(p_vec),
        .o_s_wr_en(p_wr), .o_s_addr(p_saddr), .o_s(p_s),
        .o_done(p_done)
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
        , .o_nonzero(p_nz)
`endif
    );

    // One-cycle-latency word memories.
    always @(posedge clk) begin
        if (l1_rd) begin
            l1_res <= l1_res_mem[l1_vaddr];
            l1_vec <= l1_vec_mem[l1_vaddr];
        end
        if (p_rd) begin
            p_res <= p_res_mem[p_vaddr];
            p_vec <= p_vec_mem[p_vaddr];
        end
    end

    // Monitor view of whichever instance the current run targets.
    logic        mon_rd, mon_wr, mon_done, mon_nz;
    logic [31:0] mon_vaddr, mon_saddr, mon_s;
    assign mon_rd    = sel ? p_rd : l1_rd;
    assign mon_wr    = sel ? p_wr : l1_wr;
    assign mon_done  = sel ? p_done : l1_done;
    assign mon_vaddr = sel ? 32'(p_vaddr) : 32'(l1_vaddr);
    assign mon_saddr = sel ? 32'(p_saddr) : 32'(l1_saddr);
    assign mon_s     = sel ? 32'(p_s) : 32'(l1_s);
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
    assign mon_nz    = sel ? p_nz : l1_nz;
`else
    assign mon_nz    = 1'b0;
`endif

    int assertCount = 0;
    int failCount   = 0;

    int   wrAddr[$], wrData[$], wrCycle[$];
    int   rdAddr[$], rdCycle[$];
    int   doneCycles[$];
    logic doneNz;
    int   expData[$];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Start the selected instance at edge 0 and record cycles 1..nCycles.
    task automatic applyStimulus(input bit useP, input int nCycles,
                                 input int extraStart, input int rstCycle);
        sel = useP;
        wrAddr.delete(); wrData.delete(); wrCycle.delete();
        rdAddr.delete(); rdCycle.delete(); doneCycles.delete();
        doneNz = 1'bx;
        @(negedge clk);
        if (useP) start_p = 1'b1; else start_l1 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= nCycles; n++) begin
            @(negedge clk);
            if (mon_wr) begin
                wrAddr.push_back(int'(mon_saddr));
                wrData.push_back(int'(mon_s));
                wrCycle.push_back(n);
            end
            if (mon_rd) begin
                rdAddr.push_back(int'(mon_vaddr));
                rdCycle.push_back(n);
            end
            if (mon_done) begin
                doneCycles.push_back(n);
                doneNz = mon_nz;
            end
            if (n == rstCycle + 1) begin
                checkOutput("rst_mid_wr",    32'(mon_wr),   0);
                checkOutput("rst_mid_rd",    32'(mon_rd),   0);
                checkOutput("rst_mid_done",  32'(mon_done), 0);
                checkOutput("rst_mid_s",     mon_s,         0);
                checkOutput("rst_mid_vaddr", mon_vaddr,     0);
                checkOutput("rst_mid_saddr", mon_saddr,     P_START);
            end
            if (useP) start_p = (n == extraStart); else start_l1 = (n == extraStart);
            rst = (n == rstCycle);
        end
        start_p  = 1'b0;
        start_l1 = 1'b0;
        rst      = 1'b0;
    endtask

    // Compare n captured writes from index first against expData, a
    // contiguous address range and the FETCH/LOAD/EMIT cadence.
    task automatic verifyWrites(input string tag, input int n, input int first,
                                input int base, input int offset, input int nGf);
        for (int i = 0; i < n; i++) begin
            if (first + i < wrAddr.size()) begin
                checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[first+i], base + i);
                checkOutput($sformatf("%s_data%0d", tag, i), wrData[first+i], expData[i]);
                checkOutput($sformatf("%s_cyc%0d", tag, i), wrCycle[first+i],
                            offset + 3 + (nGf + 2) * (i / nGf) + (i % nGf));
            end
        end
    endtask

    task automatic verifyReads(input string tag, input int nWords, input int offset, input int nGf);
        checkOutput({tag, "_rd_count"}, rdAddr.size(), nWords);
        for (int i = 0; i < nWords; i++) begin
            if (i < rdAddr.size()) begin
                checkOutput($sformatf("%s_rd_addr%0d", tag, i), rdAddr[i], i);
                checkOutput($sformatf("%s_rd_cyc%0d", tag, i), rdCycle[i], offset + 1 + (nGf + 2) * i);
            end
        end
    endtask

    task automatic fillP(input logic [7:0] rb, input logic [7:0] vb);
        for (int w = 0; w < 2; w++) begin
            p_res_mem[w] = {8{rb}};
            p_vec_mem[w] = {8{vb}};
        end
    endtask

    initial begin
        logic [63:0] rv, vv;
        logic [7:0]  vb;
        int          k;
        int          highCount;

        rst = 1'b1; start_l1 = 1'b0; start_p = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_l1_wr",    32'(l1_wr),    0);
        checkOutput("reset_l1_rd",    32'(l1_rd),    0);
        checkOutput("reset_l1_done",  32'(l1_done),  0);
        checkOutput("reset_l1_saddr", 32'(l1_saddr), 126);
        checkOutput("reset_l1_vaddr", 32'(l1_vaddr), 0);
        checkOutput("reset_l1_s",     32'(l1_s),     0);
        checkOutput("reset_p_saddr",  32'(p_saddr),  P_START);
        checkOutput("reset_p_wr",     32'(p_wr),     0);
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
        checkOutput("reset_p_nz",     32'(p_nz),     0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // GF256 L1: S byte k = k+1, res = vec ^ S; pad bytes hold junk.
        for (int w = 0; w < 13; w++) begin
            for (int j = 0; j < 8; j++) begin
                k  = 8 * w + j;
                vb = 8'((k * 37 + 5) & 255);
                vv[63-8*j -: 8] = vb;
                rv[63-8*j -: 8] = (k < 104) ? (vb ^ 8'(k + 1)) : 8'hEE;
            end
            l1_res_mem[w] = rv;
            l1_vec_mem[w] = vv;
        end
        expData.delete();
        for (int i = 0; i < 104; i++) expData.push_back(i + 1);
        applyStimulus(1'b0, 140, -1, -1);
        checkOutput("l1_wr_count", wrAddr.size(), 104);
        verifyWrites("l1", 104, 0, 126, 0, 8);
        verifyReads("l1", 13, 0, 8);
        checkOutput("l1_done_count", doneCycles.size(), 1);
        if (doneCycles.size() > 0) checkOutput("l1_done_cycle", doneCycles[0], 131);

        // P251: 5 - 7 = 249 everywhere; extra start in cycle 5 is ignored.
        fillP(8'd5, 8'd7);
        expData.delete();
        for (int i = 0; i < P_BYTES; i++) expData.push_back(249);
        applyStimulus(1'b1, 25, 5, -1);
        checkOutput("p_wr_count", wrAddr.size(), P_BYTES);
        verifyWrites("p", P_BYTES, 0, P_START, 0, 8);
        verifyReads("p", 2, 0, 8);
        checkOutput("p_done_count", doneCycles.size(), 1);
        if (doneCycles.size() > 0) checkOutput("p_done_cycle", doneCycles[0], 15);
        highCount = 0;
        foreach (wrAddr[i]) if (wrAddr[i] >= 13) highCount++;
        checkOutput("p_addr_high_writes", highCount, 0);
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
        checkOutput("p_nz_249", 32'(doneNz), 1);
`endif

        // res = vec: all zero; pad bytes differ but must not be written or
        // flagged. Start on the o_done cycle (15) is ignored.
        fillP(8'h37, 8'h37);
        p_res_mem[1][47:0] = {6{8'h40}};
        p_vec_mem[1][47:0] = {6{8'h10}};
        expData.delete();
        for (int i = 0; i < P_BYTES; i++) expData.push_back(0);
        applyStimulus(1'b1, 25, 15, -1);
        checkOutput("zero_wr_count", wrAddr.size(), P_BYTES);
        verifyWrites("zero", P_BYTES, 0, P_START, 0, 8);
        checkOutput("zero_rd_count", rdAddr.size(), 2);
        checkOutput("zero_done_count", doneCycles.size(), 1);
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
        checkOutput("zero_nz", 32'(doneNz), 0);
`endif

        // Only the byte destined for address 12 (word 1, byte 1) differs.
        p_res_mem[1][55:48] = 8'h39;
        expData[9] = 2;
        applyStimulus(1'b1, 25, -1, -1);
        checkOutput("one_wr_count", wrAddr.size(), P_BYTES);
        verifyWrites("one", P_BYTES, 0, P_START, 0, 8);
`ifdef VEC_SUB_UNPACK_NZ_FLAG_EN
        checkOutput("one_nz", 32'(doneNz), 1);
`endif

        // Reset sampled at edge 7: writes in cycles 3..7 only, no done.
        fillP(8'd5, 8'd7);
        expData.delete();
        for (int i = 0; i < P_BYTES; i++) expData.push_back(249);
        applyStimulus(1'b1, 25, -1, 7);
        checkOutput("rst_wr_count", wrAddr.size(), 5);
        verifyWrites("rst", 5, 0, P_START, 0, 8);
        checkOutput("rst_rd_count", rdAddr.size(), 1);
        checkOutput("rst_done_count", doneCycles.size(), 0);

        // Fresh start after the aborted run.
        applyStimulus(1'b1, 25, -1, -1);
        checkOutput("fresh_wr_count", wrAddr.size(), P_BYTES);
        verifyWrites("fresh", P_BYTES, 0, P_START, 0, 8);
        if (doneCycles.size() > 0) checkOutput("fresh_done_cycle", doneCycles[0], 15);
        else checkOutput("fresh_done_count", doneCycles.size(), 1);

        // Back-to-back: second start in cycle 16, one cycle after o_done.
        applyStimulus(1'b1, 40, 16, -1);
        checkOutput("b2b_wr_count", wrAddr.size(), 2 * P_BYTES);
        verifyWrites("b2b_a", P_BYTES, 0, P_START, 0, 8);
        verifyWrites("b2b_b", P_BYTES, P_BYTES, P_START, 16, 8);
        checkOutput("b2b_done_count", doneCycles.size(), 2);
        if (doneCycles.size() > 1) begin
            checkOutput("b2b_done0", doneCycles[0], 15);
            checkOutput("b2b_done1", doneCycles[1], 31);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vec_sub_unpack.md
# vec_sub_unpack

Inverse of the vector-add datapath. Reads two word-wide vectors (`i_res`, `i_vec`) from row-packed memories, computes the per-byte field difference `res - vec`, and writes the result one byte per cycle into byte-addressed S memory from `S_START_ADDR` upward. It recovers the S segment from a packed sum row and sits between the word-packed row buffers and the byte-wide S RAM.

## Interface
- FIELD, "GF256": "GF256" (subtract = XOR) or "P251" (subtract mod 251).
- PARAMETER_SET, "L1": selects defaults.
- MAT_ROW_SIZE_BYTES, 104/159/202 for L1/L3/L5: bytes to recover.
- M, 230/352/480: S memory depth. Requires S_START_ADDR + MAT_ROW_SIZE_BYTES <= M.
- S_START_ADDR, 126/120/150: first S byte address written.
- N_GF, 8: bytes per word.
- PROC_SIZE, N_GF*8: word width.
- W (derived), ceil(MAT_ROW_SIZE_BYTES/N_GF): words per row.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in S_IDLE.
- o_vec_rd  out  1  read strobe for both word memories.
- o_vec_addr  out  clog2(W)  word address for both memories.
- i_res  in  PROC_SIZE  packed sum word; valid the cycle after o_vec_rd.
- i_vec  in  PROC_SIZE  packed subtrahend word; same timing as i_res.
- o_s_wr_en  out  1  S memory write enable.
- o_s_addr  out  clog2(M)  S byte address.
- o_s  out  8  S byte data.
- o_done  out  1  one-cycle completion pulse.

## Operation
- Reset: every output is 0 except o_s_addr = S_START_ADDR. FSM goes to S_IDLE and the shift register clears.
- S_IDLE: o_vec_addr=0, o_s_addr=S_START_ADDR, word counter w=0. i_start=1 moves to S_FETCH.
- S_FETCH: o_vec_rd=1, o_vec_addr=w. Moves to S_LOAD.
- S_LOAD: computes diff byte j = i_res byte j minus i_vec byte j for all j. Byte j is bits [PROC_SIZE-8j-1 -: 8]. Diffs load into a PROC_SIZE shift register. Byte counter c=0. Moves to S_EMIT.
- S_EMIT: o_s_wr_en=1 and o_s = shift register MSB byte. The register shifts left 8 each cycle, c increments, o_s_addr increments after each write. Emits N_GF bytes, except the last word (w=W-1), which emits MAT_ROW_SIZE_BYTES - N_GF*(W-1) bytes.
  - After the final byte of a word: if w<W-1, then w++ and go to S_FETCH; else go to S_DONE.
- S_DONE: o_done=1 for one cycle, then S_IDLE.
- P251 subtract: a>=b ? a-b : a-b+251, computed in 9 bits and truncated to 8. Inputs are < 251 by contract.
- Pad bytes in the last word (low PAD bits) are never written.
- Address rule: byte j of word w goes to S_START_ADDR + N_GF*w + j. o_s_addr never exceeds S_START_ADDR+MAT_ROW_SIZE_BYTES-1 while o_s_wr_en=1.
- i_start while busy is ignored. i_start in the cycle o_done=1 is ignored; the FSM is not yet in S_IDLE.
- i_rst mid-operation: the next cycle shows reset values. No further writes or reads are issued.

## Timing
- Memory read latency is exactly 1 cycle.
- i_start=1 at edge 0 puts S_FETCH in cycle 1.
- A full word takes N_GF+2 cycles.
- o_done is high in cycle 1 + 2W + MAT_ROW_SIZE_BYTES. For L1 that is cycle 131.
- Writes are contiguous within a word, with a 2-cycle gap (FETCH, LOAD) between words.
- o_s, o_s_addr and o_s_wr_en are registered and aligned in the same cycle.

## Configuration
- VEC_SUB_UNPACK_NZ_FLAG_EN defined: adds output o_nonzero (1 bit).
  - Cleared on i_start acceptance and on reset.
  - Sticky-ORs (o_s != 0) on every write.
  - Valid from the o_done cycle until the next start.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- GF256, L1, i_res = i_vec ^ pattern where S byte k = k+1:
  - 104 writes, address 126..229 with data 1..104.
  - o_done in cycle 131, no writes after.
- P251, MAT_ROW_SIZE_BYTES=10, N_GF=8, S_START_ADDR=3, res bytes 5 and vec bytes 7 everywhere:
  - 10 writes of 249 at addresses 3..12.
  - Writes in cycles 3-10 and 13-14, o_done in cycle 15.
  - Addresses 13+ never written.
- Same config, res = vec: all bytes 0. With VEC_SUB_UNPACK_NZ_FLAG_EN, o_nonzero=0.
  - Change one byte at addr 12 to nonzero: o_nonzero=1.
- i_start pulsed again in cycle 5 of a run: ignored, and the write sequence is unchanged.
  - i_start on the o_done cycle is also ignored.
- i_rst asserted in cycle 7:
  - Cycle 8 shows all outputs at reset values and o_s_addr=S_START_ADDR.
  - No o_done.
  - A fresh start completes normally.
- Back-to-back runs (start in the cycle after o_done): the second run's write sequence and timing are identical to the first.
